// File: rtl/vga_syncgen.sv
// VGA 640x480@60 raster timing: pixel-clock divider, H/V counters and registered HS/VS/DE.
// Optional FRAME_START pulse when VGA_SYNCGEN_FRAME_START_EN is defined.
module vga_syncgen #(
    parameter int CLKDIV  = 4,
    parameter int HDISP   = 640,
    parameter int HFRONT  = 16,
    parameter int HWIDTH  = 96,
    parameter int HPERIOD = 800,
    parameter int VDISP   = 480,
    parameter int VFRONT  = 10,
    parameter int VWIDTH  = 2,
    parameter int VPERIOD = 525
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       PCK,
    output logic       PCK_EN,
    output logic [9:0] HCNT,
    output logic [9:0] VCNT,
    output logic       HS,
    output logic       VS,
    output logic       DE
`ifdef VGA_SYNCGEN_FRAME_START_EN
    ,
    output logic       FRAME_START
`endif
);

    localparam int DW = $clog2(CLKDIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLKDIV / 2);

    localparam logic [9:0] H_LAST     = 10'(HPERIOD - 1);
    localparam logic [9:0] H_DISP     = 10'(HDISP);
    localparam logic [9:0] H_SYNC_BEG = 10'(HDISP + HFRONT);
    localparam logic [9:0] H_SYNC_END = 10'(HDISP + HFRONT + HWIDTH);

    localparam logic [9:0] V_LAST     = 10'(VPERIOD - 1);
    localparam logic [9:0] V_DISP     = 10'(VDISP);
    localparam logic [9:0] V_SYNC_BEG = 10'(VDISP + VFRONT);
    localparam logic [9:0] V_SYNC_END = 10'(VDISP + VFRONT + VWIDTH);

    logic [DW-1:0] div;
    logic [DW-1:0] div_next;
    logic [9:0]    hcnt_next;
    logic [9:0]    vcnt_next;
    logic          de_next;
    logic          hs_next;
    logic          vs_next;
    logic          h_wrap;

    always_comb begin
        div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
    end

    // Counters move only on the cycle after the strobe; otherwise they hold.
    always_comb begin
        hcnt_next = HCNT;
        vcnt_next = VCNT;
        h_wrap    = 1'b0;
        if (PCK_EN) begin
            if (HCNT == H_LAST) begin
                hcnt_next = '0;
                h_wrap    = 1'b1;
            end else begin
                hcnt_next = HCNT + 10'd1;
            end
            if (h_wrap) begin
                vcnt_next = (VCNT == V_LAST) ? '0 : VCNT + 10'd1;
            end
        end
    end

    // Decode from the next counter values so sync/enable line up with HCNT/VCNT.
    always_comb begin
        de_next = (hcnt_next < H_DISP) && (vcnt_next < V_DISP);
        hs_next = !((hcnt_next >= H_SYNC_BEG) && (hcnt_next < H_SYNC_END));
        vs_next = !((vcnt_next >= V_SYNC_BEG) && (vcnt_next < V_SYNC_END));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div    <= '0;
            PCK    <= 1'b0;
            PCK_EN <= 1'b0;
        end else begin
            div    <= div_next;
            PCK    <= (div_next >= DIV_HALF);
            PCK_EN <= (div_next == DIV_LAST);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            HCNT <= H_LAST;
            VCNT <= V_LAST;
            HS   <= 1'b1;
            VS   <= 1'b1;
            DE   <= 1'b0;
        end else begin
            HCNT <= hcnt_next;
            VCNT <= vcnt_next;
            HS   <= hs_next;
            VS   <= vs_next;
            DE   <= de_next;
        end
    end

`ifdef VGA_SYNCGEN_FRAME_START_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            FRAME_START <= 1'b0;
        end else begin
            FRAME_START <= PCK_EN && (hcnt_next == '0) && (vcnt_next == '0);
        end
    end
`endif

endmodule

// File: doc/vga_syncgen.md
Name: vga_syncgen

Overview:
Generates VGA 640x480@60 Hz raster timing from the 100 MHz board clock.
- Divides CLK by CLKDIV to get a pixel clock and a pixel-enable strobe.
- Runs the horizontal and vertical counters.
- Produces registered HS/VS/DE aligned with the counters.
Sits directly upstream of the pattern/colour stage, which consumes HCNT/VCNT/DE/PCK_EN and re-times HS/VS onto VGA_HS/VGA_VS.

Parameters:
CLKDIV, 4, CLK cycles per pixel; even, >=2
HDISP, 640, active pixels per line
HFRONT, 16, horizontal front porch (pixels)
HWIDTH, 96, HS pulse width (pixels)
HPERIOD, 800, total pixels per line
VDISP, 480, active lines per frame
VFRONT, 10, vertical front porch (lines)
VWIDTH, 2, VS pulse width (lines)
VPERIOD, 525, total lines per frame

Ports:
CLK  input  1  system clock, 100 MHz
RST  input  1  asynchronous, active-low reset
PCK  output  1  pixel clock, CLK/CLKDIV, 50% duty
PCK_EN  output  1  one-CLK strobe, marks pixel-advance cycle
HCNT  output  10  horizontal position 0..HPERIOD-1
VCNT  output  10  vertical position 0..VPERIOD-1
HS  output  1  horizontal sync, active low
VS  output  1  vertical sync, active low
DE  output  1  display enable, high in active area

Behaviour:
- All state uses posedge CLK and async clear on RST=0. No other clock domain; PCK is an output only, never used as a clock internally.
- Divider:
  - DIV counts 0..CLKDIV-1 and wraps.
  - PCK_EN=1 exactly when DIV==CLKDIV-1 (registered).
  - PCK=1 when DIV>=CLKDIV/2 (registered).
- Reset values: DIV=0, PCK=0, PCK_EN=0, HCNT=HPERIOD-1, VCNT=VPERIOD-1, HS=1, VS=1, DE=0.
- Counters advance only in the cycle after PCK_EN is sampled high. Effective advance rate is one pixel per CLKDIV CLKs.
- HCNT: increments; at HPERIOD-1 it wraps to 0.
- VCNT: increments only when HCNT wraps. VCNT at VPERIOD-1 plus an HCNT wrap gives VCNT=0.
- First advance after reset lands on HCNT=0, VCNT=0, which is the first active pixel of a frame.
- Decode is computed from next-state counter values and registered, so HS/VS/DE are valid in the same cycle as the matching HCNT/VCNT. Zero latency relative to the counters.
  - DE = (HCNT<HDISP) && (VCNT<VDISP).
  - HS = 0 iff HDISP+HFRONT <= HCNT < HDISP+HFRONT+HWIDTH, i.e. 656..751.
  - VS = 0 iff VDISP+VFRONT <= VCNT < VDISP+VFRONT+VWIDTH, i.e. 490..491. VS changes at the HCNT=0 boundary.
- HS/VS/DE/HCNT/VCNT hold their value between pixel advances.
- Frame length is HPERIOD*VPERIOD*CLKDIV = 1,680,000 CLK.
- Reset asserted mid-frame: every output returns to its reset value immediately (async). Timing restarts cleanly at frame start on release.
- No illegal states: counter values >= PERIOD cannot occur. Counter widths are sized for the defaults; larger parameters are out of scope.

Optional Feature:
VGA_SYNCGEN_FRAME_START_EN
- Defined: adds output FRAME_START (1 bit, reset 0). It is a one-CLK pulse in the same cycle the counters land on HCNT=0, VCNT=0. Downstream uses it for frame-synchronous updates such as pattern animation.
- Not defined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Hold RST=0 for 10 CLK -> HCNT=799, VCNT=524, HS=1, VS=1, DE=0, PCK=0, PCK_EN=0. Release -> first PCK_EN at CLK 4 after release, then HCNT=0, VCNT=0, DE=1.
- Free-run one line -> PCK_EN period is 4 CLK; PCK is 2 high / 2 low; DE falls when HCNT goes 639->640; HS low for exactly 96 pixels (HCNT 656..751); HCNT wraps 799->0 and VCNT increments.
- Free-run full frame -> VS low only on VCNT 490..491 (2 lines); DE never 1 for VCNT>=480; VCNT wraps 524->0; 1,680,000 CLK between successive HCNT=0/VCNT=0 events.
- Assert RST=0 at mid-frame (HCNT=300, VCNT=200) for 3 CLK, asynchronously between edges -> outputs go to reset values without waiting for a CLK edge; after release, timing matches the first scenario.
- Parameter override CLKDIV=2 -> PCK_EN every 2 CLK; frame length 840,000 CLK; HS/VS pixel positions unchanged.
- With VGA_SYNCGEN_FRAME_START_EN -> FRAME_START is one CLK wide, coincident with HCNT=0/VCNT=0, once per 1,680,000 CLK, and 0 during reset.
